// File: rtl/lane_steer_pkg.sv
// ============================================================================
// lane_steer_pkg : shared mode encodings and FSM state constants
// Rev 1.0
// ============================================================================
`default_nettype none

package lane_steer_pkg;

  localparam logic [1:0] MODE_RR   = 2'b00;
  localparam logic [1:0] MODE_L0   = 2'b01;
  localparam logic [1:0] MODE_L1   = 2'b10;
  localparam logic [1:0] MODE_DATA = 2'b11;

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/lane_credit_ctr.sv
// ============================================================================
// lane_credit_ctr : CREDITS-initialised saturating up/down credit counter
// Rev 1.0
// ============================================================================
`default_nettype none

module lane_credit_ctr #(
  parameter int CREDITS = 4,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          overflow
);

  localparam logic [CW-1:0] FULL = CW'(CREDITS);
  localparam logic [CW-1:0] ONE  = CW'(1);

  // A return that arrives while already full is dropped and flagged.
  assign overflow = inc & ~dec & (count == FULL);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= FULL;
    end else if (dec && !inc) begin
      count <= count - ONE;
    end else if (inc && !dec && (count != FULL)) begin
      count <= count + ONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lane_steer_ctrl.sv
// ============================================================================
// lane_steer_ctrl : one-entry steering stage driving the 1-to-2 DeMux sel/a
// Rev 1.0
// ============================================================================
`default_nettype none

module lane_steer_ctrl
  import lane_steer_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CREDITS = 4,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       mode,
  output logic             sel,
  output logic             a_pulse,
  output logic [WIDTH-1:0] a_data,
  input  logic             ret0,
  input  logic             ret1,
  output logic [CW-1:0]    credit0,
  output logic [CW-1:0]    credit1,
  output logic             busy,
  output logic             err
);

  logic [0:0]       state;
  logic [WIDTH-1:0] hold_data;
  logic [1:0]       hold_mode;
  logic             rr_ptr;
  logic             lane;
  logic             issue_now;
  logic             accept;
  logic [CW-1:0]    count [2];
  logic [1:0]       ret;
  logic [1:0]       ovf;

  assign ret = {ret1, ret0};

  // Lane is resolved from the mode captured with the held item, not the live input.
  always_comb begin
    lane = 1'b0;
    case (hold_mode)
      MODE_RR: begin
        if (count[rr_ptr] != '0)       lane = rr_ptr;
        else if (count[~rr_ptr] != '0) lane = ~rr_ptr;
        else                           lane = rr_ptr;
      end
      MODE_L0:   lane = 1'b0;
      MODE_L1:   lane = 1'b1;
      MODE_DATA: lane = hold_data[0];
      default:   lane = 1'b0;
    endcase
  end

  assign issue_now = (state == HOLD) && (count[lane] != '0);
  assign in_ready  = (state == EMPTY) || issue_now;
  assign accept    = in_valid && in_ready;
  assign busy      = (state == HOLD);

  for (genvar i = 0; i < 2; i++) begin : g_lane
    lane_credit_ctr #(
      .CREDITS (CREDITS),
      .CW      (CW)
    ) u_ctr (
      .clock    (clock),
      .reset    (reset),
      .dec      (issue_now && (lane == 1'(i))),
      .inc      (ret[i]),
      .count    (count[i]),
      .overflow (ovf[i])
    );
  end

  assign credit0 = count[0];
  assign credit1 = count[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= EMPTY;
      hold_data <= '0;
      hold_mode <= MODE_RR;
      rr_ptr    <= 1'b0;
      sel       <= 1'b0;
      a_pulse   <= 1'b0;
      a_data    <= '0;
      err       <= 1'b0;
    end else begin
      a_pulse <= issue_now;
      err     <= err | ovf[0] | ovf[1];
      if (issue_now) begin
        sel    <= lane;
        a_data <= hold_data;
        if (hold_mode == MODE_RR) rr_ptr <= ~lane;
      end
      if (accept) begin
        state     <= HOLD;
        hold_data <= in_data;
        hold_mode <= mode;
      end else if (issue_now) begin
        state <= EMPTY;
      end
    end
  end

endmodule

`default_nettype wire
